// File: rtl/alu_result_sequencer_if.sv
// alu_result_sequencer_if: control-side request, ALU drive/capture and writeback strobes
interface alu_result_sequencer_if #(
  parameter int DATA_W    = 32,
  parameter int REG_SEL_W = 4
);
  logic                 start;
  logic [4:0]           op;
  logic [DATA_W-1:0]    a_in;
  logic [DATA_W-1:0]    b_in;
  logic [REG_SEL_W-1:0] dest;
  logic [4:0]           alu_ops;
  logic [DATA_W-1:0]    alu_a;
  logic [DATA_W-1:0]    alu_b;
  logic [2*DATA_W-1:0]  alu_z;
  logic                 busy;
  logic                 reg_we;
  logic [REG_SEL_W-1:0] reg_wsel;
  logic [DATA_W-1:0]    wdata;
  logic                 lo_we;
  logic                 hi_we;
  logic                 done;
  logic                 illegal;
  modport master (
    output start, op, a_in, b_in, dest, alu_z,
    input  alu_ops, alu_a, alu_b, busy, reg_we, reg_wsel, wdata, lo_we, hi_we, done, illegal
  );
  modport slave (
    input  start, op, a_in, b_in, dest, alu_z,
    output alu_ops, alu_a, alu_b, busy, reg_we, reg_wsel, wdata, lo_we, hi_we, done, illegal
  );
endinterface

// File: rtl/alu_result_sequencer.sv
// alu_result_sequencer: issues a latched op to the ALU, captures ZHI/ZLO and writes back to GP or HI/LO
module alu_result_sequencer #(
  parameter int DATA_W    = 32,
  parameter int REG_SEL_W = 4
) (
  input logic clock,
  input logic clear,
  alu_result_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOAD, EXEC, WB_LO, WB_HI, DONE} state_t;
  state_t               state, nxt;
  logic [DATA_W-1:0]    y, b, zhi, zlo;
  logic [4:0]           op_r;
  logic [REG_SEL_W-1:0] dest_r;
  logic                 legal, wide;
  assign legal = op_r inside {5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                              5'd10, 5'd11, 5'd15, 5'd16, 5'd17, 5'd18};
  assign wide  = op_r == 5'd15 || op_r == 5'd16;
  always_ff @(posedge clock or posedge clear)
    if (clear) begin
      state  <= IDLE;
      y      <= '0;
      b      <= '0;
      zhi    <= '0;
      zlo    <= '0;
      op_r   <= '0;
      dest_r <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && bus.start) begin
        op_r   <= bus.op;
        y      <= bus.a_in;
        b      <= bus.b_in;
        dest_r <= bus.dest;
      end
      if (state == EXEC) {zhi, zlo} <= bus.alu_z;
    end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = bus.start ? LOAD : IDLE;
      LOAD:    nxt = legal ? EXEC : DONE;
      EXEC:    nxt = WB_LO;
      WB_LO:   nxt = wide ? WB_HI : DONE;
      WB_HI:   nxt = DONE;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    bus.busy     = state inside {LOAD, EXEC, WB_LO, WB_HI};
    bus.alu_ops  = state == EXEC ? op_r : '0;
    bus.alu_a    = state == EXEC ? y : '0;
    bus.alu_b    = state == EXEC ? b : '0;
    bus.reg_we   = state == WB_LO && !wide;
    bus.lo_we    = state == WB_LO && wide;
    bus.hi_we    = state == WB_HI;
    bus.reg_wsel = bus.reg_we ? dest_r : '0;
    bus.wdata    = state == WB_LO ? zlo : state == WB_HI ? zhi : '0;
    bus.done     = state == DONE;
    bus.illegal  = state == DONE && !legal;
  end
endmodule
